// File: rtl/irq_pending_latch.sv
`default_nettype none
// ============================================================================
// Module   : irq_pending_latch
// Purpose  : Capture stage ahead of priority_encoder_4to2. It synchronises four
//            asynchronous request lines, turns them into events and holds each
//            event as a pending bit. A pending bit stays set until the consumer
//            acknowledges it with the encoder's 2-bit code
//            (00=D3, 01=D2, 10=D1, 11=D0).
// Params   : SYNC_STAGES - synchroniser depth per request line (legal 2..4)
//            EDGE_MODE   - 1: event on a rising edge of the synced line
//                          0: event while the synced line is high
// Config   : IRQ_MASK_EN - when defined, adds the mask port. D3..D0 then come
//            from a registered pend & ~mask stage, one cycle behind pend.
//            When undefined, D3..D0 are the pending flops themselves.
// Ports    : clk       in  1  clock, rising edge
//            rst_n     in  1  asynchronous active-low reset
//            req_in    in  4  async requests, bit3->D3 ... bit0->D0
//            ack       in  1  strobe: clear the pending bit chosen by ack_code
//            ack_code  in  2  encoder code of the bit to clear
//            ovr_clr   in  1  clears all overrun flags
//            mask      in  4  1 hides a bit from the encoder (IRQ_MASK_EN only)
//            D3..D0    out 1  pending bits towards the encoder
//            pend_cnt  out 3  number of raw pending bits (0..4)
//            ovr       out 4  sticky per-bit overrun flags
//            ack_err   out 1  one-cycle pulse: ack_code selected a clear bit
// Revision : 1.0 - initial release
// ============================================================================
module irq_pending_latch #(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_in,
  input  logic       ack,
  input  logic [1:0] ack_code,
  input  logic       ovr_clr,
`ifdef IRQ_MASK_EN
  input  logic [3:0] mask,
`endif
  output logic       D3,
  output logic       D2,
  output logic       D1,
  output logic       D0,
  output logic [2:0] pend_cnt,
  output logic [3:0] ovr,
  output logic       ack_err
);

  // Synchroniser: one 4-bit slice per stage, slice 0 samples req_in.
  logic [SYNC_STAGES-1:0][3:0] r_sync;
  logic [3:0]                  w_sync_s;

  logic [3:0] w_event;
  logic       w_ovr_en;

  logic [3:0] r_pend;
  logic [3:0] r_ovr;
  logic       r_ack_err;

  logic [1:0] w_idx;
  logic [3:0] w_sel;
  logic [3:0] w_clr;
  logic [3:0] w_pend_next;
  logic [3:0] w_ovr_set;
  logic [3:0] w_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], req_in};
    end
  end

  assign w_sync_s = r_sync[SYNC_STAGES-1];

  generate
    if (EDGE_MODE != 0) begin : g_edge
      logic [3:0] r_sync_prev;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sync_prev <= '0;
        end else begin
          r_sync_prev <= w_sync_s;
        end
      end

      assign w_event  = w_sync_s & ~r_sync_prev;
      assign w_ovr_en = 1'b1;
    end else begin : g_level
      // A held level is one continuous request, so it can never overrun.
      assign w_event  = w_sync_s;
      assign w_ovr_en = 1'b0;
    end
  endgenerate

  // Encoder code 00 names D3, so the bit index is the code reversed.
  assign w_idx = 2'd3 - ack_code;
  assign w_sel = 4'b0001 << w_idx;
  assign w_clr = {4{ack}} & w_sel;

  // A new event beats a same-cycle clear of the same bit.
  assign w_pend_next = w_event | (r_pend & ~w_clr);

  // Overrun only when the bit would otherwise have stayed pending.
  assign w_ovr_set = {4{w_ovr_en}} & w_event & r_pend & ~w_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend    <= '0;
      r_ovr     <= '0;
      r_ack_err <= 1'b0;
    end else begin
      r_pend    <= w_pend_next;
      // New overruns are OR-ed in after the clear so they survive ovr_clr.
      r_ovr     <= (r_ovr & ~{4{ovr_clr}}) | w_ovr_set;
      r_ack_err <= ack & ~(|(r_pend & w_sel));
    end
  end

`ifdef IRQ_MASK_EN
  logic [3:0] r_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d <= '0;
    end else begin
      r_d <= r_pend & ~mask;
    end
  end

  assign w_d = r_d;
`else
  assign w_d = r_pend;
`endif

  assign {D3, D2, D1, D0} = w_d;

  assign pend_cnt = {2'b00, r_pend[0]} + {2'b00, r_pend[1]}
                  + {2'b00, r_pend[2]} + {2'b00, r_pend[3]};
  assign ovr      = r_ovr;
  assign ack_err  = r_ack_err;

endmodule
`default_nettype wire
